// File: rtl/pacman_pkg.sv
// Shared encodings, default geometry and mask shapes for the PAC-MAN display path.
package pacman_pkg;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'b00,
      CELL_DOT   = 2'b01,
      CELL_BIG   = 2'b10,
      CELL_WALL  = 2'b11
   } cell_e;

   typedef enum logic [1:0] {
      MASK_PLAYER,
      MASK_GHOST,
      MASK_DOT,
      MASK_BIG
   } mask_kind_e;

   localparam int DEF_TILE_SIZE   = 20;
   localparam int DEF_TILE_COLS   = 28;
   localparam int DEF_TILE_ROWS   = 31;
   localparam int DEF_NUM_SPRITES = 5;
   localparam int DEF_COORD_W     = 10;
   localparam int DEF_COLOR_W     = 4;
   localparam int DEF_BLINK_BIT   = 4;

   localparam logic [3:0] DBG_R = 4'h7;
   localparam logic [3:0] DBG_G = 4'h4;
   localparam logic [3:0] DBG_B = 4'hF;

   // Player has a transparent one-pixel border, ghost has a skirt with gaps
   // on odd columns of its bottom row, dots are centred squares.
   function automatic logic maskPixel(input mask_kind_e kind, input int size,
                                      input int row, input int col);
      case (kind)
         MASK_PLAYER: return (row > 0) && (row < size - 1) && (col > 0) && (col < size - 1);
         MASK_GHOST:  return (row < size - 1) || ((col % 2) == 0);
         MASK_DOT:    return (row >= size / 2 - 2) && (row <= size / 2 + 1) &&
                             (col >= size / 2 - 2) && (col <= size / 2 + 1);
         default:     return (row >= size / 2 - 5) && (row <= size / 2 + 4) &&
                             (col >= size / 2 - 5) && (col <= size / 2 + 4);
      endcase
   endfunction

endpackage

// File: rtl/sprite_mask_rom.sv
// Constant pixel masks: one read port per sprite plus a shared tile port for dot shapes.
module sprite_mask_rom
   import pacman_pkg::*;
#(
   parameter int TILE_SIZE   = DEF_TILE_SIZE,
   parameter int NUM_SPRITES = DEF_NUM_SPRITES,
   parameter int OFF_W       = $clog2(TILE_SIZE)
)(
   input  logic [NUM_SPRITES*OFF_W-1:0] i_sprOffX,
   input  logic [NUM_SPRITES*OFF_W-1:0] i_sprOffY,
   input  logic [OFF_W-1:0]             i_tileOffX,
   input  logic [OFF_W-1:0]             i_tileOffY,
   output logic [NUM_SPRITES-1:0]       o_sprBit,
   output logic                         o_dotBit,
   output logic                         o_bigBit
);

   localparam int MASK_BITS = TILE_SIZE * TILE_SIZE;
   localparam int IDX_W     = $clog2(MASK_BITS);

   function automatic logic [MASK_BITS-1:0] buildMask(input mask_kind_e kind);
      logic [MASK_BITS-1:0] m;
      m = '0;
      for (int row = 0; row < TILE_SIZE; row++) begin
         for (int col = 0; col < TILE_SIZE; col++) begin
            m = m | (MASK_BITS'(maskPixel(kind, TILE_SIZE, row, col)) << (row * TILE_SIZE + col));
         end
      end
      return m;
   endfunction

   function automatic logic [IDX_W-1:0] bitIndex(input logic [OFF_W-1:0] row,
                                                 input logic [OFF_W-1:0] col);
      return IDX_W'(row) * IDX_W'(TILE_SIZE) + IDX_W'(col);
   endfunction

   localparam logic [MASK_BITS-1:0] PLAYER_MASK = buildMask(MASK_PLAYER);
   localparam logic [MASK_BITS-1:0] GHOST_MASK  = buildMask(MASK_GHOST);
   localparam logic [MASK_BITS-1:0] DOT_MASK    = buildMask(MASK_DOT);
   localparam logic [MASK_BITS-1:0] BIG_MASK    = buildMask(MASK_BIG);

   always_comb begin
      o_sprBit = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (i == 0)
            o_sprBit[i] = PLAYER_MASK[bitIndex(i_sprOffY[i*OFF_W +: OFF_W], i_sprOffX[i*OFF_W +: OFF_W])];
         else
            o_sprBit[i] = GHOST_MASK[bitIndex(i_sprOffY[i*OFF_W +: OFF_W], i_sprOffX[i*OFF_W +: OFF_W])];
      end
   end

   assign o_dotBit = DOT_MASK[bitIndex(i_tileOffY, i_tileOffX)];
   assign o_bigBit = BIG_MASK[bitIndex(i_tileOffY, i_tileOffX)];

endmodule

// File: rtl/tile_sprite_compositor.sv
// Three-stage tile/sprite pixel compositor: S0 tile lookup, S1 map read and sprite hits,
// S2 priority colour select. Sprite state is latched once per frame to avoid tearing.
module tile_sprite_compositor
   import pacman_pkg::*;
#(
   parameter int TILE_SIZE   = DEF_TILE_SIZE,
   parameter int TILE_COLS   = DEF_TILE_COLS,
   parameter int TILE_ROWS   = DEF_TILE_ROWS,
   parameter int NUM_SPRITES = DEF_NUM_SPRITES,
   parameter int COORD_W     = DEF_COORD_W,
   parameter int COLOR_W     = DEF_COLOR_W,
   parameter int BLINK_BIT   = DEF_BLINK_BIT
)(
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  pix_valid,
   input  logic [COORD_W-1:0]                    pix_x,
   input  logic [COORD_W-1:0]                    pix_y,
   input  logic                                  de,
   input  logic                                  frame_start,
   input  logic                                  playing,
   input  logic                                  blink_en,
   input  logic [NUM_SPRITES*COORD_W-1:0]        spr_x,
   input  logic [NUM_SPRITES*COORD_W-1:0]        spr_y,
   input  logic [NUM_SPRITES-1:0]                spr_en,
   input  logic [NUM_SPRITES*3*COLOR_W-1:0]      spr_rgb,
   output logic [$clog2(TILE_COLS*TILE_ROWS)-1:0] map_addr,
   input  logic [1:0]                            map_cell,
   output logic                                  rgb_valid,
   output logic [COLOR_W-1:0]                    r,
   output logic [COLOR_W-1:0]                    g,
   output logic [COLOR_W-1:0]                    b
);

   localparam int ADDR_W = $clog2(TILE_COLS * TILE_ROWS);
   localparam int OFF_W  = $clog2(TILE_SIZE);
   localparam int RGB_W  = 3 * COLOR_W;

   localparam logic [COORD_W-1:0] TS_C   = COORD_W'(TILE_SIZE);
   localparam logic [COORD_W:0]   TS_E   = (COORD_W + 1)'(TILE_SIZE);
   localparam logic [COORD_W-1:0] COLS_C = COORD_W'(TILE_COLS);
   localparam logic [COORD_W-1:0] ROWS_C = COORD_W'(TILE_ROWS);
   localparam logic [ADDR_W-1:0]  COLS_A = ADDR_W'(TILE_COLS);

   // Keeps the top bits of a 4-bit debug channel, zero-extending on wider channels.
   function automatic logic [COLOR_W-1:0] scaleColor(input logic [3:0] c);
      return COLOR_W'(({c, {COLOR_W{1'b0}}}) >> 4);
   endfunction

   localparam logic [RGB_W-1:0] DEBUG_RGB = {scaleColor(DBG_R), scaleColor(DBG_G), scaleColor(DBG_B)};
   localparam logic [RGB_W-1:0] WALL_RGB  = {{(2*COLOR_W){1'b0}}, {COLOR_W{1'b1}}};
   localparam logic [RGB_W-1:0] WHITE_RGB = {RGB_W{1'b1}};

   logic [NUM_SPRITES*COORD_W-1:0]   r_shX;
   logic [NUM_SPRITES*COORD_W-1:0]   r_shY;
   logic [NUM_SPRITES-1:0]           r_shEn;
   logic [NUM_SPRITES*RGB_W-1:0]     r_shRgb;
   logic [7:0]                       r_frameCnt;

   logic [COORD_W-1:0]               w_tileCol;
   logic [COORD_W-1:0]               w_tileRow;
   logic                             w_inMap;

   logic                             r0Valid;
   logic                             r0De;
   logic                             r0Playing;
   logic                             r0InMap;
   logic [COORD_W-1:0]               r0X;
   logic [COORD_W-1:0]               r0Y;
   logic [OFF_W-1:0]                 r0OffX;
   logic [OFF_W-1:0]                 r0OffY;

   logic [NUM_SPRITES-1:0]           w_hit;
   logic [NUM_SPRITES*OFF_W-1:0]     w_sprOffX;
   logic [NUM_SPRITES*OFF_W-1:0]     w_sprOffY;
   logic [NUM_SPRITES-1:0]           w_sprMaskBit;
   logic                             w_dotBit;
   logic                             w_bigBit;
   logic                             w_sprWin;
   logic [RGB_W-1:0]                 w_sprWinRgb;

   logic                             r1Valid;
   logic                             r1De;
   logic                             r1Playing;
   cell_e                            r1Cell;
   logic                             r1DotBit;
   logic                             r1BigBit;
   logic                             r1SprWin;
   logic [RGB_W-1:0]                 r1SprRgb;

   logic                             w_blinkOff;
   logic [RGB_W-1:0]                 w_pixRgb;

   // Sprite state only moves at frame boundaries; a pixel in S1 during the
   // frame_start cycle still sees the old values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shX      <= '0;
         r_shY      <= '0;
         r_shEn     <= '0;
         r_shRgb    <= '0;
         r_frameCnt <= '0;
      end else if (frame_start) begin
         r_shX      <= spr_x;
         r_shY      <= spr_y;
         r_shEn     <= spr_en;
         r_shRgb    <= spr_rgb;
         r_frameCnt <= r_frameCnt + 8'd1;
      end
   end

   assign w_tileCol = pix_x / TS_C;
   assign w_tileRow = pix_y / TS_C;
   assign w_inMap   = (w_tileCol < COLS_C) && (w_tileRow < ROWS_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r0Valid   <= 1'b0;
         r0De      <= 1'b0;
         r0Playing <= 1'b0;
         r0InMap   <= 1'b0;
         r0X       <= '0;
         r0Y       <= '0;
         r0OffX    <= '0;
         r0OffY    <= '0;
         map_addr  <= '0;
      end else begin
         r0Valid   <= pix_valid;
         r0De      <= de;
         r0Playing <= playing;
         r0InMap   <= w_inMap;
         r0X       <= pix_x;
         r0Y       <= pix_y;
         r0OffX    <= OFF_W'(pix_x % TS_C);
         r0OffY    <= OFF_W'(pix_y % TS_C);
         map_addr  <= w_inMap ? (ADDR_W'(w_tileRow) * COLS_A + ADDR_W'(w_tileCol)) : '0;
      end
   end

   // Bounds are compared one bit wider so a sprite near the right/bottom edge
   // cannot wrap around and claim pixels on the opposite side.
   always_comb begin
      w_hit     = '0;
      w_sprOffX = '0;
      w_sprOffY = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_hit[i] = r_shEn[i] &&
                    ({1'b0, r0X} >= {1'b0, r_shX[i*COORD_W +: COORD_W]}) &&
                    ({1'b0, r0X} <  ({1'b0, r_shX[i*COORD_W +: COORD_W]} + TS_E)) &&
                    ({1'b0, r0Y} >= {1'b0, r_shY[i*COORD_W +: COORD_W]}) &&
                    ({1'b0, r0Y} <  ({1'b0, r_shY[i*COORD_W +: COORD_W]} + TS_E));
         w_sprOffX[i*OFF_W +: OFF_W] = OFF_W'(r0X - r_shX[i*COORD_W +: COORD_W]);
         w_sprOffY[i*OFF_W +: OFF_W] = OFF_W'(r0Y - r_shY[i*COORD_W +: COORD_W]);
      end
   end

   sprite_mask_rom #(
      .TILE_SIZE   (TILE_SIZE),
      .NUM_SPRITES (NUM_SPRITES),
      .OFF_W       (OFF_W)
   ) u_maskRom (
      .i_sprOffX  (w_sprOffX),
      .i_sprOffY  (w_sprOffY),
      .i_tileOffX (r0OffX),
      .i_tileOffY (r0OffY),
      .o_sprBit   (w_sprMaskBit),
      .o_dotBit   (w_dotBit),
      .o_bigBit   (w_bigBit)
   );

   // Walking from the highest index down leaves the lowest visible sprite as winner.
   always_comb begin
      w_sprWin    = 1'b0;
      w_sprWinRgb = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (w_hit[i] && w_sprMaskBit[i]) begin
            w_sprWin    = 1'b1;
            w_sprWinRgb = r_shRgb[i*RGB_W +: RGB_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1Valid   <= 1'b0;
         r1De      <= 1'b0;
         r1Playing <= 1'b0;
         r1Cell    <= CELL_EMPTY;
         r1DotBit  <= 1'b0;
         r1BigBit  <= 1'b0;
         r1SprWin  <= 1'b0;
         r1SprRgb  <= '0;
      end else begin
         r1Valid   <= r0Valid;
         r1De      <= r0De;
         r1Playing <= r0Playing;
         r1Cell    <= r0InMap ? cell_e'(map_cell) : CELL_EMPTY;
         r1DotBit  <= w_dotBit;
         r1BigBit  <= w_bigBit;
         r1SprWin  <= w_sprWin;
         r1SprRgb  <= w_sprWinRgb;
      end
   end

   assign w_blinkOff = ((r_frameCnt >> BLINK_BIT) & 8'd1) != 8'd0;

   always_comb begin
      w_pixRgb = '0;
      if (!r1De)
         w_pixRgb = '0;
      else if (!r1Playing)
         w_pixRgb = DEBUG_RGB;
      else if (r1Cell == CELL_WALL)
         w_pixRgb = WALL_RGB;
      else if (r1SprWin)
         w_pixRgb = r1SprRgb;
      else if ((r1Cell == CELL_DOT) && r1DotBit)
         w_pixRgb = WHITE_RGB;
      else if ((r1Cell == CELL_BIG) && r1BigBit && (!blink_en || !w_blinkOff))
         w_pixRgb = WHITE_RGB;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_valid <= 1'b0;
         r         <= '0;
         g         <= '0;
         b         <= '0;
      end else begin
         rgb_valid <= r1Valid;
         {r, g, b} <= r1Valid ? w_pixRgb : '0;
      end
   end

endmodule

// File: tb/tb_tile_sprite_compositor.sv
// Directed bench for the tile/sprite compositor with a combinational tile-map model.
module tb_tile_sprite_compositor;

   localparam int ADDR_W = 10;

   logic        clk;
   logic        rst_n;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        de;
   logic        frame_start;
   logic        playing;
   logic        blink_en;
   logic [49:0] spr_x;
   logic [49:0] spr_y;
   logic [4:0]  spr_en;
   logic [59:0] spr_rgb;
   logic [ADDR_W-1:0] map_addr;
   logic [1:0]  map_cell;
   logic        rgb_valid;
   logic [3:0]  r;
   logic [3:0]  g;
   logic [3:0]  b;

   logic [1:0]  mapMem [0:1023];
   logic [ADDR_W-1:0] lastAddr;
   logic [7:0]  frameModel;
   int          checkCount;
   int          failCount;

   tile_sprite_compositor dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .de          (de),
      .frame_start (frame_start),
      .playing     (playing),
      .blink_en    (blink_en),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .spr_en      (spr_en),
      .spr_rgb     (spr_rgb),
      .map_addr    (map_addr),
      .map_cell    (map_cell),
      .rgb_valid   (rgb_valid),
      .r           (r),
      .g           (g),
      .b           (b)
   );

   assign map_cell = mapMem[map_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one pixel for a single cycle and returns at the sampling point of its output.
   task automatic applyStimulus(input int x, input int y);
      pix_x = 10'(x);
      pix_y = 10'(y);
      pix_valid = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0;
      lastAddr = map_addr;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic expValid, input logic [11:0] expRgb);
      checkCount++;
      assert ({rgb_valid, r, g, b} === {expValid, expRgb}) else begin
         failCount++;
         $error("[TB] FAIL %s: observed valid/rgb %h expected %h", tag, {rgb_valid, r, g, b}, {expValid, expRgb});
      end
   endtask

   task automatic checkAddr(input string tag, input logic [ADDR_W-1:0] observed, input logic [ADDR_W-1:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed map_addr %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic frameTick();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      frameModel = frameModel + 8'd1;
   endtask

   task automatic setSprite(input int idx, input int x, input int y, input logic en, input logic [11:0] rgb);
      spr_x[idx*10 +: 10]   = 10'(x);
      spr_y[idx*10 +: 10]   = 10'(y);
      spr_en[idx]           = en;
      spr_rgb[idx*12 +: 12] = rgb;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checkCount = 0;
      failCount  = 0;
      frameModel = 8'd0;
      rst_n = 1'b1;
      pix_valid = 1'b0;
      pix_x = '0;
      pix_y = '0;
      de = 1'b1;
      frame_start = 1'b0;
      playing = 1'b1;
      blink_en = 1'b0;
      spr_x = '0;
      spr_y = '0;
      spr_en = '0;
      spr_rgb = '0;
      for (int i = 0; i < 1024; i++) mapMem[i] = 2'b00;
      mapMem[0]  = 2'b11;
      mapMem[3]  = 2'b10;
      mapMem[57] = 2'b01;
      #1 rst_n = 1'b0;

      // Pixels presented while reset is held produce nothing.
      @(negedge clk);
      pix_valid = 1'b1;
      pix_x = 10'd5;
      pix_y = 10'd5;
      repeat (3) @(negedge clk);
      checkOutput("reset_out", 1'b0, 12'h000);
      checkAddr("reset_addr", map_addr, 10'd0);
      pix_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // Wall at tile (0,0): colour appears on the third edge, not the second.
      pix_x = 10'd5;
      pix_y = 10'd5;
      pix_valid = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
      checkOutput("latency_early", 1'b0, 12'h000);
      @(negedge clk);
      checkOutput("wall", 1'b1, 12'h00F);
      @(negedge clk);
      checkOutput("idle_zero", 1'b0, 12'h000);

      // Dot at tile col 1 row 2 (address 57); centre drawn, corner offset blank.
      applyStimulus(30, 50);
      checkAddr("addr_57", lastAddr, 10'd57);
      checkOutput("dot_centre", 1'b1, 12'hFFF);
      applyStimulus(25, 45);
      checkOutput("dot_outside", 1'b1, 12'h000);

      // Column 30 is off the map: address clamps to 0 and the wall there is ignored.
      applyStimulus(600, 5);
      checkAddr("oob_addr", lastAddr, 10'd0);
      checkOutput("oob_empty", 1'b1, 12'h000);

      // Sprites are invisible until a frame_start latches them.
      setSprite(0, 40, 40, 1'b1, 12'hFF0);
      setSprite(1, 45, 40, 1'b1, 12'h0F0);
      applyStimulus(50, 50);
      checkOutput("spr_preframe", 1'b1, 12'h000);
      frameTick();
      applyStimulus(50, 50);
      checkOutput("spr0_priority", 1'b1, 12'hFF0);
      applyStimulus(40, 45);
      checkOutput("player_border", 1'b1, 12'h000);
      applyStimulus(46, 59);
      checkOutput("ghost_skirt_gap", 1'b1, 12'h000);
      applyStimulus(47, 59);
      checkOutput("ghost_skirt_fill", 1'b1, 12'h0F0);

      spr_en[0] = 1'b0;
      frameTick();
      applyStimulus(50, 50);
      checkOutput("spr1_only", 1'b1, 12'h0F0);

      // Position changes stay hidden until the next frame boundary.
      spr_en[0] = 1'b1;
      frameTick();
      spr_x[9:0] = 10'd200;
      applyStimulus(50, 50);
      checkOutput("shadow_hold", 1'b1, 12'hFF0);
      frameTick();
      applyStimulus(50, 50);
      checkOutput("shadow_update", 1'b1, 12'h0F0);

      // frame_start while the pixel sits in S1: that pixel keeps the old position.
      spr_x[9:0] = 10'd40;
      pix_x = 10'd50;
      pix_y = 10'd50;
      pix_valid = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      frameModel = frameModel + 8'd1;
      @(negedge clk);
      checkOutput("fs_inflight_old", 1'b1, 12'h0F0);
      applyStimulus(50, 50);
      checkOutput("fs_after_new", 1'b1, 12'hFF0);

      // Big dot at tile col 3 row 0 blinks on frame counter bit 4.
      blink_en = 1'b1;
      while (frameModel[4:0] != 5'd15) frameTick();
      applyStimulus(70, 10);
      checkOutput("blink_f15_on", 1'b1, 12'hFFF);
      frameTick();
      applyStimulus(70, 10);
      checkOutput("blink_f16_off", 1'b1, 12'h000);
      blink_en = 1'b0;
      applyStimulus(70, 10);
      checkOutput("noblink_f16_on", 1'b1, 12'hFFF);
      blink_en = 1'b1;
      while (frameModel[4:0] != 5'd31) frameTick();
      applyStimulus(70, 10);
      checkOutput("blink_f31_off", 1'b1, 12'h000);
      frameTick();
      applyStimulus(70, 10);
      checkOutput("blink_f32_on", 1'b1, 12'hFFF);

      // Sprite at the coordinate limit must not wrap onto the left edge.
      setSprite(2, 1015, 20, 1'b1, 12'hA5C);
      frameTick();
      applyStimulus(1020, 25);
      checkOutput("edge_sprite_hit", 1'b1, 12'hA5C);
      applyStimulus(3, 25);
      checkOutput("edge_no_wrap", 1'b1, 12'h000);

      // Not playing: debug colour overrides wall and sprites, but not blanking.
      playing = 1'b0;
      applyStimulus(5, 5);
      checkOutput("debug_wall", 1'b1, 12'h74F);
      applyStimulus(50, 50);
      checkOutput("debug_sprite", 1'b1, 12'h74F);
      de = 1'b0;
      applyStimulus(5, 5);
      checkOutput("blank_de", 1'b1, 12'h000);
      de = 1'b1;
      playing = 1'b1;

      // Reset while a pixel is in flight drops it and clears the sprite shadows.
      pix_x = 10'd50;
      pix_y = 10'd50;
      pix_valid = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_flush", 1'b0, 12'h000);
      applyStimulus(50, 50);
      checkOutput("reset_shadow_clear", 1'b1, 12'h000);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
